// File: rtl/ccff_chain_loader.sv
// Config-chain writer: streams words MSB-first onto ccff_head, captures ccff_tail as readback words.
// Latency: one bit per prog_clk with cfg_valid held; done within CHAIN_LEN + NUM_WORDS + 2 cycles of start.
// Backpressure: cfg_ready only in FETCH / last SHIFT cycle; chain clock gated during bubbles; readback has none.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt
);
    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
    localparam int PAD       = WORD_W - LAST_BITS;
    localparam int BL_W      = $clog2(WORD_W + 1);
    localparam int WC_W      = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [WORD_W-1:0] shift_reg;
    logic [BL_W-1:0]   bits_left;
    logic [WC_W-1:0]   words_taken;

    logic [WORD_W-1:0] rb_reg;
    logic [BL_W-1:0]   rb_bits;
    logic [CNT_W-1:0]  cap_cnt;

    logic              last_bit;
    logic              more_words;
    logic              accept;
    logic [BL_W-1:0]   next_len;
    logic [WORD_W-1:0] rb_next;
    logic [WORD_W-1:0] rb_word;
    logic              word_full;
    logic              chain_full;

    assign last_bit   = (state == ST_SHIFT) && (bits_left == BL_W'(1));
    assign more_words = (words_taken != WC_W'(NUM_WORDS));
    // Opening the next fetch during the last shift cycle keeps the enable gap-free.
    assign cfg_ready  = (state == ST_FETCH) || (last_bit && more_words);
    assign accept     = cfg_valid && cfg_ready;
    assign next_len   = (words_taken == WC_W'(NUM_WORDS - 1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bits_left   <= '0;
            words_taken <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            ccff_clk_en <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_FETCH;
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        words_taken <= '0;
                    end
                end
                ST_FETCH: begin
                    if (accept) begin
                        shift_reg   <= cfg_data;
                        bits_left   <= next_len;
                        words_taken <= words_taken + WC_W'(1);
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    ccff_head   <= shift_reg[WORD_W-1];
                    ccff_clk_en <= 1'b1;
                    shift_reg   <= shift_reg << 1;
                    bit_cnt     <= bit_cnt + CNT_W'(1);
                    bits_left   <= bits_left - BL_W'(1);
                    if (last_bit) begin
                        if (accept) begin
                            shift_reg   <= cfg_data;
                            bits_left   <= next_len;
                            words_taken <= words_taken + WC_W'(1);
                        end else if (more_words) begin
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    // DRAIN: the final enabled edge ends this cycle.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    assign rb_next    = (rb_reg << 1) | WORD_W'(ccff_tail);
    assign word_full  = (rb_bits == BL_W'(WORD_W - 1));
    assign chain_full = (cap_cnt == CNT_W'(CHAIN_LEN - 1));
    assign rb_word    = chain_full ? (rb_next << PAD) : rb_next;

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            rb_reg   <= '0;
            rb_bits  <= '0;
            cap_cnt  <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            rb_valid <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                rb_reg  <= '0;
                rb_bits <= '0;
                cap_cnt <= '0;
            end else if (ccff_clk_en) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
                if (word_full || chain_full) begin
                    rb_valid <= 1'b1;
                    rb_data  <= rb_word;
                    rb_reg   <= '0;
                    rb_bits  <= '0;
                end else begin
                    rb_reg  <= rb_next;
                    rb_bits <= rb_bits + BL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: default 20/8 instance plus an 8/8 single-word instance,
// each driving a behavioural config chain whose tail feeds back into the loader.
module tb_ccff_chain_loader;
    logic       prog_clk;
    logic       prog_reset;
    logic       start, cfg_valid, cfg_ready, ccff_head, ccff_clk_en, ccff_tail;
    logic [7:0] cfg_data, rb_data;
    logic       rb_valid, busy, done;
    logic [15:0] bit_cnt;

    logic       b_start, b_cfg_valid, b_cfg_ready, b_head, b_en, b_tail;
    logic [7:0] b_cfg_data, b_rb_data;
    logic       b_rb_valid, b_busy, b_done;
    logic [15:0] b_bit_cnt;

    logic [19:0] chain   = 20'hFFFFF;
    logic [7:0]  b_chain = 8'h5A;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0, done_cnt = 0, b_en_cnt = 0, b_done_cnt = 0;

    logic       exp_head[$];
    logic       obs_head[$];
    logic [7:0] exp_rb[$];
    logic [7:0] obs_rb[$];
    logic [7:0] b_exp_rb[$];
    logic [7:0] b_obs_rb[$];

    ccff_chain_loader dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
        .rb_valid(rb_valid), .rb_data(rb_data), .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(16)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_data(b_cfg_data),
        .ccff_head(b_head), .ccff_clk_en(b_en), .ccff_tail(b_tail),
        .rb_valid(b_rb_valid), .rb_data(b_rb_data), .busy(b_busy), .done(b_done), .bit_cnt(b_bit_cnt)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain model: first bit shifted in ends up at the tail end (MSB).
    assign ccff_tail = chain[19];
    assign b_tail    = b_chain[7];
    always @(posedge prog_clk) begin
        if (ccff_clk_en) chain <= {chain[18:0], ccff_head};
        if (b_en) b_chain <= {b_chain[6:0], b_head};
    end

    always @(posedge prog_clk) cyc <= cyc + 1;

    always @(negedge prog_clk) begin
        if (ccff_clk_en) begin
            en_cnt <= en_cnt + 1;
            obs_head.push_back(ccff_head);
        end
        if (rb_valid) obs_rb.push_back(rb_data);
        if (done) done_cnt <= done_cnt + 1;
        if (b_en) b_en_cnt <= b_en_cnt + 1;
        if (b_rb_valid) b_obs_rb.push_back(b_rb_data);
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_clk_en"}, ccff_clk_en, 0);
        check({tag, "_rb_valid"}, rb_valid, 0);
        check({tag, "_rb_data"}, rb_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bit_cnt"}, bit_cnt, 0);
        check({tag, "_b_busy"}, b_busy, 0);
        check({tag, "_b_bit_cnt"}, b_bit_cnt, 0);
    endtask

    task automatic drain_scoreboard(input string tag);
        check({tag, "_nbits"}, obs_head.size(), exp_head.size());
        while (exp_head.size() > 0 && obs_head.size() > 0)
            check({tag, "_head_bit"}, obs_head.pop_front(), exp_head.pop_front());
        check({tag, "_nrb"}, obs_rb.size(), exp_rb.size());
        while (exp_rb.size() > 0 && obs_rb.size() > 0)
            check({tag, "_rb_word"}, obs_rb.pop_front(), exp_rb.pop_front());
        exp_head.delete();
        exp_rb.delete();
        obs_head.delete();
        obs_rb.delete();
    endtask

    task automatic wait_hs(input string tag);
        bit got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge prog_clk);
            if (cfg_ready && cfg_valid) got = 1;
            @(posedge prog_clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_handshake"}, got, 1);
    endtask

    task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int gap, input bit mid_start,
                            input bit hold_valid);
        logic [19:0] seq;
        logic [7:0]  words [3];
        int          start_cyc, lat, done_base;
        bit          got;
        seq = {w0, w1, w2[7:4]};
        for (int i = 19; i >= 0; i--) exp_head.push_back(seq[i]);
        exp_rb.push_back(chain[19:12]);
        exp_rb.push_back(chain[11:4]);
        exp_rb.push_back({chain[3:0], 4'h0});
        words = '{w0, w1, w2};
        done_base = done_cnt;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = w0;
        start_cyc = cyc;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        wait_hs(tag);
        for (int k = 1; k < 3; k++) begin
            cfg_data = words[k];
            if (gap > 0) begin
                cfg_valid = 1'b0;
                repeat (gap) begin
                    @(posedge prog_clk);
                    #1;
                end
                cfg_valid = 1'b1;
            end
            if (mid_start && k == 1) start = 1'b1;
            wait_hs(tag);
        end
        cfg_valid = hold_valid;
        got = 0;
        lat = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge prog_clk);
            if (done) begin
                got = 1;
                lat = cyc - start_cyc;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        if (gap == 0) check({tag, "_latency_ok"}, (lat <= 25), 1);
        @(posedge prog_clk);
        #1;
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_bit_cnt"}, bit_cnt, 20);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_chain"}, chain, seq);
        drain_scoreboard(tag);
    endtask

    initial begin
        int  base, done_base;
        bit  got;
        start = 0; cfg_valid = 0; cfg_data = 0;
        b_start = 0; b_cfg_valid = 0; b_cfg_data = 0;
        prog_reset = 1'b1;
        #1 prog_reset = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b1;
        @(posedge prog_clk);
        #1;

        run_load("load1", 8'hA5, 8'h3C, 8'h9F, 0, 0, 0);
        check("load1_bits_hold", bit_cnt, 20);

        run_load("load2", 8'h00, 8'h00, 8'h00, 0, 1, 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge prog_clk);
            check("idle_cfg_ready", cfg_ready, 0);
        end
        @(posedge prog_clk);
        #1;
        check("idle_no_enable", obs_head.size(), 0);
        check("idle_bit_cnt_hold", bit_cnt, 20);
        cfg_valid = 1'b0;

        // 8 shift cycles are covered by the gap, leaving ~5 bubble cycles in FETCH.
        run_load("gap", 8'hA5, 8'h3C, 8'h9F, 13, 0, 0);

        for (int i = 7; i >= 1; i--) begin
            logic [7:0] w = 8'h12;
            exp_head.push_back(w[i]);
        end
        done_base = done_cnt;
        base = en_cnt;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'h12;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        wait_hs("abort");
        cfg_data = 8'h34;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge prog_clk);
            #1;
            if (en_cnt - base >= 7) got = 1;
        end
        check("abort_reach7", got, 1);
        #1 prog_reset = 1'b0;
        #1 check_zero("abort");
        repeat (3) begin
            @(posedge prog_clk);
            #1;
        end
        check("abort_no_done", done_cnt - done_base, 0);
        drain_scoreboard("abort");
        cfg_valid = 1'b0;
        prog_reset = 1'b1;
        @(posedge prog_clk);
        #1;
        run_load("fresh", 8'h12, 8'h34, 8'h56, 0, 0, 0);

        b_exp_rb.push_back(b_chain);
        b_start = 1'b1;
        b_cfg_valid = 1'b1;
        b_cfg_data = 8'h81;
        @(posedge prog_clk);
        #1;
        b_start = 1'b0;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge prog_clk);
            if (b_done) got = 1;
        end
        @(posedge prog_clk);
        #1;
        b_cfg_valid = 1'b0;
        check("b_done_seen", got, 1);
        check("b_chain", b_chain, 8'h81);
        check("b_en_count", b_en_cnt, 8);
        check("b_bit_cnt", b_bit_cnt, 8);
        check("b_done_pulses", b_done_cnt, 1);
        check("b_nrb", b_obs_rb.size(), b_exp_rb.size());
        while (b_obs_rb.size() > 0 && b_exp_rb.size() > 0)
            check("b_rb_word", b_obs_rb.pop_front(), b_exp_rb.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer end of the configuration-chain (ccff) protocol.
- Accepts configuration words over a valid/ready stream and serializes them onto ccff_head, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits.
- Captures the previous chain contents emerging on ccff_tail as a readback word stream.
- Sits between the bitstream source and the head of a tile's config chain; drives the chain's clock-enable so bubbles never corrupt the chain.

Parameters:
- CHAIN_LEN, 20, number of config flip-flops in the target chain (≥1).
- WORD_W, 8, config/readback word width (≥1).
- CNT_W, 16, width of the bit counter; must hold CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock.
- prog_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config word accepted when cfg_valid & cfg_ready.
- cfg_data  in  WORD_W  config word; MSB is shifted first.
- ccff_head  out  1  serial bit to chain head (registered).
- ccff_clk_en  out  1  chain clock enable (registered); the chain shifts at the prog_clk edge ending a cycle with ccff_clk_en=1.
- ccff_tail  in  1  chain tail bit.
- rb_valid  out  1  one-cycle pulse, readback word available.
- rb_data  out  WORD_W  readback word; first-emerged bit in MSB.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last bit has shifted.
- bit_cnt  out  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (prog_reset=0, asynchronous): state IDLE; all outputs 0; shift register and counters cleared.
- Reset asserted mid-load aborts the load immediately: ccff_clk_en=0 and no done pulse. The chain is left partially shifted; software must restart.
- Sizing: NUM_WORDS = ceil(CHAIN_LEN/WORD_W); LAST_BITS = CHAIN_LEN − (NUM_WORDS−1)·WORD_W. Only the LAST_BITS MSBs of the final word are shifted; its remaining LSBs are ignored.
- States and transitions:
  - IDLE: cfg_ready=0. start → FETCH; bit_cnt←0; busy←1.
  - FETCH: cfg_ready=1. On handshake, load the shift register and set bits_left to WORD_W, or LAST_BITS for the final word → SHIFT. Until the handshake: ccff_clk_en=0 and the chain holds, so bubbles are harmless.
  - SHIFT: every cycle registers ccff_head←MSB and ccff_clk_en←1, shifts the register left, and increments bit_cnt. When bits_left reaches 0: go to FETCH if more words remain, else DRAIN.
  - FETCH timing: cfg_ready may be asserted in the last SHIFT cycle, giving back-to-back words with no enable gap. One bit per cycle is sustained when cfg_valid is held high.
  - DRAIN: one cycle to let the final enabled edge complete → IDLE with done=1 and busy=0.
- Readback:
  - On each enabled edge, ccff_tail (sampled before the shift, i.e. the old last-FF value) is shifted into the rb register LSB.
  - rb_valid pulses the cycle after every WORD_W-th captured bit, and after the final bit.
  - A partial final word is left-justified: captured bits in the MSBs, LSBs zero.
  - There is no back-pressure on readback.
- start while busy: ignored.
- cfg_valid in IDLE: ignored (cfg_ready=0).
- Exactly CHAIN_LEN enabled edges occur per load, never more. The final bit_cnt equals CHAIN_LEN and holds until the next start.
- Latency: with cfg_valid held high, done pulses CHAIN_LEN + NUM_WORDS + 2 cycles after start at most.

Test Plan:
- Defaults; chain model preloaded with 0xFFFFF; words 0xA5, 0x3C, 0x9F streamed continuously → ccff_head serial sequence A5,3C,9 (20 bits, MSB first); exactly 20 ccff_clk_en cycles; model chain = 0xA53C9; rb words 0xFF, 0xFF, 0xF0; done pulses once; bit_cnt=20.
- Same load with cfg_valid deasserted for 5 cycles between words → ccff_clk_en gaps only in FETCH; identical final chain 0xA53C9.
- Second load 0x00, 0x00, 0x00 after the first → readback 0xA5, 0x3C, 0x90; chain = 0.
- start pulsed again mid-load, and cfg_valid held high in IDLE → no effect; cfg_ready=0 in IDLE; enable count still 20.
- prog_reset driven low after 7 bits → all outputs 0 asynchronously; no done. A fresh load afterwards completes normally with 20 enabled edges.
- CHAIN_LEN=8, WORD_W=8 → single word 0x81 loads; one rb_valid; done; no partial-word padding.
